// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if
// Groups the observation inputs and result outputs of the gate response checker.
//   master : stimulus/observation side. It drives start, in_a, in_b and dut_c,
//            and reads the results.
//   slave  : checker side. It reads the observed signals and drives busy, done,
//            pass, err_count, cov, last_fail_idx and fail_seen.
// CNT_W must match the CNT_W of the checker that is attached to this interface.
interface gate_truth_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             in_a;
  logic             in_b;
  logic             dut_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       cov;
  logic [1:0]       last_fail_idx;
  logic             fail_seen;

  modport master (
    output start, in_a, in_b, dut_c,
    input  busy, done, pass, err_count, cov, last_fail_idx, fail_seen
  );

  modport slave (
    input  start, in_a, in_b, dut_c,
    output busy, done, pass, err_count, cov, last_fail_idx, fail_seen
  );
endinterface

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Passive response monitor for a 2-input gate under test. Each new {a,b} input
// pattern has to stay stable for SETTLE_CYCLES edges. The edge on which the
// pattern is first sampled counts as edge 1. On the last of those edges, dut_c
// is compared with TRUTH_TABLE[{a,b}]. Mismatches are counted (saturating) and
// per-pattern coverage is tracked. The checker reports done/pass once all four
// patterns have been checked.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : slave modport carrying start/in_a/in_b/dut_c and all results
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset; results hold, waiting for start
// SETTLE   | current pattern is being timed until it is stable enough
// WAIT_CHG | current pattern already checked; waiting for a new pattern
// DONE     | all four patterns checked; done/pass held until start/rst
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1110,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                 clk,
  input logic                 rst,
  gate_truth_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_CHG, DONE} state_t;

  localparam logic [7:0]       LAST    = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [7:0]       cnt_q;
  logic             busy_q, done_q, pass_q, fail_seen_q;
  logic [CNT_W-1:0] err_q;
  logic [3:0]       cov_q;
  logic [1:0]       last_fail_idx_q;

  logic [1:0]       pat;
  logic [7:0]       cnt_d;
  logic             do_check;
  logic             mismatch;
  logic [3:0]       cov_d;
  logic [CNT_W-1:0] err_d;

  // cnt counts the edges the pattern has been seen, minus one. A pattern that
  // differs from idx starts over at 0, which is its first edge. When
  // SETTLE_CYCLES=1, the check therefore fires on the edge where the pattern
  // changes, including a change that is seen while in WAIT_CHG.
  always_comb begin
    pat      = {bus.in_a, bus.in_b};
    cnt_d    = (pat == idx_q) ? cnt_q + 8'd1 : 8'd0;
    do_check = ((state_q == SETTLE) || (state_q == WAIT_CHG && pat != idx_q))
               && (cnt_d >= LAST);
    mismatch = (bus.dut_c != TRUTH_TABLE[pat]);
    cov_d    = cov_q | (4'b0001 << pat);
    err_d    = err_q;
    if (mismatch && err_q != ERR_MAX) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= 2'b00;
      cnt_q           <= 8'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_seen_q     <= 1'b0;
      err_q           <= '0;
      cov_q           <= 4'b0000;
      last_fail_idx_q <= 2'b00;
    end else if (bus.start) begin
      // The edge that carries start is counted as the first edge of the
      // pattern sampled on it.
      state_q         <= SETTLE;
      idx_q           <= pat;
      cnt_q           <= 8'd0;
      busy_q          <= 1'b1;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_seen_q     <= 1'b0;
      err_q           <= '0;
      cov_q           <= 4'b0000;
      last_fail_idx_q <= 2'b00;
    end else begin
      case (state_q)
        SETTLE, WAIT_CHG: begin
          idx_q <= pat;
          if (do_check) begin
            cnt_q <= 8'd0;
            cov_q <= cov_d;
            err_q <= err_d;
            if (mismatch) begin
              last_fail_idx_q <= pat;
              fail_seen_q     <= 1'b1;
            end
            if (cov_d == 4'b1111) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q <= WAIT_CHG;
            end
          end else if (state_q == SETTLE) begin
            cnt_q <= cnt_d;
          end else if (pat != idx_q) begin
            state_q <= SETTLE;
            cnt_q   <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.cov           = cov_q;
  assign bus.last_fail_idx = last_fail_idx_q;
  assign bus.fail_seen     = fail_seen_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_a = 1'b0, in_b = 1'b0, dut_c = 1'b0;
  always #5 clk = ~clk;

  gate_truth_checker_if #(.CNT_W(8)) bus0 ();
  gate_truth_checker_if #(.CNT_W(2)) bus1 ();

  assign bus0.start = start;
  assign bus0.in_a  = in_a;
  assign bus0.in_b  = in_b;
  assign bus0.dut_c = dut_c;
  assign bus1.start = start;
  assign bus1.in_a  = in_a;
  assign bus1.in_b  = in_b;
  assign bus1.dut_c = dut_c;

  gate_truth_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(4), .CNT_W(8))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_truth_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(1), .CNT_W(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic       busy, done, pass, fs;
    logic [7:0] err;
    logic [3:0] cov;
    logic [1:0] lfi;
  } snap_t;

  snap_t q0[$];
  snap_t q1[$];
  int checks = 0;
  int failures = 0;

  // Reference model: each instance is IDLE, LOOK (timing a pattern), WAIT
  // (already checked, waiting for a change) or FIN (all four patterns covered).
  // run is the number of consecutive edges on which the current pattern has been seen.
  localparam int M_IDLE = 0, M_LOOK = 1, M_WAIT = 2, M_FIN = 3;
  int settle[2] = '{4, 1};
  int emax[2]   = '{255, 3};
  int mode[2], cur[2], run[2], err[2], cov[2], lfi[2], fs[2];
  int gate_mode = 0;  // 0 OR, 1 AND, 2 stuck-at-0, 3 random

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input int i, input int p, input int c);
    cov[i] = cov[i] | (1 << p);
    if (c != (((p >> 1) | p) & 1)) begin  // reference gate: OR of a and b
      err[i] = (err[i] + 1 > emax[i]) ? emax[i] : err[i] + 1;
      lfi[i] = p;
      fs[i]  = 1;
    end
    mode[i] = (cov[i] == 15) ? M_FIN : M_WAIT;
  endtask

  task automatic model_edge(input int i, input int r, input int s, input int p, input int c);
    if (r != 0) begin
      mode[i] = M_IDLE; cur[i] = 0; run[i] = 0;
      err[i] = 0; cov[i] = 0; lfi[i] = 0; fs[i] = 0;
    end else if (s != 0) begin
      mode[i] = M_LOOK; cur[i] = p; run[i] = 1;
      err[i] = 0; cov[i] = 0; lfi[i] = 0; fs[i] = 0;
    end else if (mode[i] == M_LOOK) begin
      if (p == cur[i]) run[i]++;
      else begin cur[i] = p; run[i] = 1; end
      if (run[i] >= settle[i]) model_check(i, p, c);
    end else if (mode[i] == M_WAIT && p != cur[i]) begin
      cur[i] = p; run[i] = 1; mode[i] = M_LOOK;
      if (run[i] >= settle[i]) model_check(i, p, c);
    end
  endtask

  function automatic snap_t snap(input int i);
    snap_t s;
    s.busy = (mode[i] == M_LOOK || mode[i] == M_WAIT);
    s.done = (mode[i] == M_FIN);
    s.pass = (mode[i] == M_FIN) && (err[i] == 0);
    s.fs   = fs[i][0];
    s.err  = 8'(err[i]);
    s.cov  = 4'(cov[i]);
    s.lfi  = 2'(lfi[i]);
    return s;
  endfunction

  // One clock cycle of stimulus. It drives on the falling edge and pushes the
  // results expected after the next rising edge.
  task automatic cyc(input int r, input int s, input int p);
    int c;
    case (gate_mode)
      0: c = ((p >> 1) | p) & 1;
      1: c = ((p >> 1) & p) & 1;
      2: c = 0;
      default: c = int'($urandom_range(0, 1));
    endcase
    rst = r[0]; start = s[0]; in_a = p[1]; in_b = p[0]; dut_c = c[0];
    for (int i = 0; i < 2; i++) model_edge(i, r, s, p, c);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    @(negedge clk);
  endtask

  task automatic hold(input int p, input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, p);
  endtask

  task automatic four_patterns(input int n);
    cyc(0, 1, 0);
    hold(0, n - 1);
    hold(1, n);
    hold(2, n);
    hold(3, n);
  endtask

  // Monitor: compares every cycle's registered results against the scoreboard.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_busy", int'(bus0.busy), int'(e.busy));
        chk("d0_done", int'(bus0.done), int'(e.done));
        chk("d0_pass", int'(bus0.pass), int'(e.pass));
        chk("d0_fail_seen", int'(bus0.fail_seen), int'(e.fs));
        chk("d0_err_count", int'(bus0.err_count), int'(e.err));
        chk("d0_cov", int'(bus0.cov), int'(e.cov));
        chk("d0_last_fail_idx", int'(bus0.last_fail_idx), int'(e.lfi));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_busy", int'(bus1.busy), int'(e.busy));
        chk("d1_done", int'(bus1.done), int'(e.done));
        chk("d1_pass", int'(bus1.pass), int'(e.pass));
        chk("d1_fail_seen", int'(bus1.fail_seen), int'(e.fs));
        chk("d1_err_count", int'(bus1.err_count), int'(e.err));
        chk("d1_cov", int'(bus1.cov), int'(e.cov));
        chk("d1_last_fail_idx", int'(bus1.last_fail_idx), int'(e.lfi));
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) model_edge(i, 1, 0, 0, 0);
    @(negedge clk);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("reset_err", int'(bus0.err_count), 0);
    chk("reset_cov", int'(bus0.cov), 0);
    hold(1, 3); hold(2, 5); hold(3, 2);            // no start: nothing is checked
    chk("idle_cov", int'(bus0.cov), 0);

    gate_mode = 0;                                 // correct OR
    four_patterns(10);
    chk("or_done", int'(bus0.done), 1);
    chk("or_pass", int'(bus0.pass), 1);
    chk("or_cov", int'(bus0.cov), 15);
    hold(3, 3);

    gate_mode = 1;                                 // AND-behaving gate
    four_patterns(10);
    chk("and_err", int'(bus0.err_count), 2);
    chk("and_lfi", int'(bus0.last_fail_idx), 2);
    chk("and_pass", int'(bus0.pass), 0);

    gate_mode = 0;                                 // restart from a failed DONE
    cyc(0, 1, 0);
    chk("restart_done", int'(bus0.done), 0);
    chk("restart_busy", int'(bus0.busy), 1);
    hold(0, 9); hold(1, 10); hold(2, 10); hold(3, 10);
    chk("restart_pass", int'(bus0.pass), 1);

    cyc(0, 1, 0); hold(0, 5);                      // glitch: 01 only for 2 edges
    hold(1, 2); hold(0, 5);
    chk("glitch_cov1", int'(bus0.cov[1]), 0);
    chk("glitch_busy", int'(bus0.busy), 1);

    gate_mode = 2;                                 // stuck-at-0: saturation
    cyc(0, 1, 0); hold(0, 5);
    for (int k = 0; k < 5; k++) begin hold(1, 6); hold(0, 6); end
    chk("sat_err0", int'(bus0.err_count), 5);
    chk("sat_err1", int'(bus1.err_count), 3);
    chk("sat_cov", int'(bus0.cov), 3);

    gate_mode = 0;                                 // reset in the middle of a run
    cyc(0, 1, 0); hold(0, 5); hold(1, 6);
    cyc(1, 0, 1);
    hold(2, 6); hold(3, 6);
    chk("rst_cov", int'(bus0.cov), 0);

    for (int it = 0; it < 300; it++) begin         // randomized runs
      int p, n, r;
      if ((it % 25) == 0) gate_mode = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      p = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 7));
      if (r < 3) cyc(1, 0, p);
      else if (r < 12) cyc(0, 1, p);
      hold(p, n);
    end

    @(posedge clk); #2;
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Synthesizable response monitor for a 2-input gate under test (e.g. an OR built from NANDs). It is the checking end that pairs with a stimulus sequencer.
- Passively observes the DUT inputs `in_a`/`in_b` and the output `dut_c`.
- Waits for each new input pattern to settle, then compares `dut_c` against a parameterised truth table.
- Counts mismatches and tracks pattern coverage. Reports pass/fail once all four input combinations have been checked.

Parameters:
- TRUTH_TABLE, 4'b1110, expected output indexed by {a,b} (bit0 = 00 … bit3 = 11); default is OR.
- SETTLE_CYCLES, 4, number of consecutive stable clock edges before `dut_c` is compared; legal range 1..255.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse: clear results and begin monitoring.
- in_a  input  1  DUT input a, as observed; synchronous to clk.
- in_b  input  1  DUT input b, as observed; synchronous to clk.
- dut_c  input  1  DUT output, as observed; synchronous to clk.
- busy  output  1  high while monitoring (SETTLE/WAIT_CHG).
- done  output  1  high once all 4 patterns are checked; held.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  CNT_W  number of mismatches, saturating.
- cov  output  4  coverage bitmap; bit i is set once pattern i has been checked.
- last_fail_idx  output  2  {a,b} of the most recent mismatch.
- fail_seen  output  1  sticky; set on any mismatch.

Behaviour:
- Reset: state=IDLE; busy, done, pass, fail_seen = 0; err_count=0; cov=4'b0000; last_fail_idx=2'b00; internal idx=0, cnt=0.
- Inputs are sampled directly at each rising edge. There is no internal synchronizer; the bench/DUT must be clk-synchronous.
- States: IDLE, SETTLE, WAIT_CHG, DONE.
- start (any state, rst=0):
  - Next state SETTLE.
  - Clear err_count, cov, fail_seen, last_fail_idx, done, pass.
  - idx <= {in_a,in_b}; cnt <= 0.
  - start has priority over every other transition. rst has priority over start.
- IDLE: outputs hold; start is ignored only when rst=1.
- SETTLE, per edge:
  - If {in_a,in_b} != idx: idx <= new value, cnt <= 0. No check.
  - Else if cnt == SETTLE_CYCLES-1:
    - Compare dut_c with TRUTH_TABLE[idx]. The check therefore occurs at the SETTLE_CYCLES-th edge counting the edge at which the pattern was first sampled as edge 1.
    - Set cov[idx].
    - On mismatch: err_count <= err_count+1, saturating at 2^CNT_W-1; last_fail_idx <= idx; fail_seen <= 1.
    - Next state: DONE if (cov | onehot(idx)) == 4'b1111, else WAIT_CHG.
  - Else cnt <= cnt+1.
- WAIT_CHG:
  - dut_c is ignored.
  - When {in_a,in_b} != idx: idx <= new value, cnt <= 0, go to SETTLE.
  - Re-applying an already-covered pattern is checked again and may add errors.
- DONE: done=1; pass=(err_count==0); busy=0. Holds until start or rst.
- Results are visible on outputs the cycle after the checking edge (all outputs registered).
- Boundary cases:
  - SETTLE_CYCLES=1: check on the first edge a new pattern is seen.
  - A pattern held fewer than SETTLE_CYCLES edges is never checked and does not set cov.
  - Saturated err_count stays at max; fail_seen stays 1.
  - rst mid-operation returns every output to reset values on that edge.
  - start during DONE clears done/pass on the same edge.

Test Plan:
- Correct OR DUT, start, then apply 00,01,10,11 each held 10 cycles -> done=1 after the 11 check, pass=1, err_count=0, cov=4'b1111, fail_seen=0.
- AND-behaving DUT (c=a&b), same sequence -> err_count=2 (patterns 01 and 10 fail), last_fail_idx=2'b10, fail_seen=1, done=1, pass=0.
- Glitch: correct DUT, pattern 01 held 2 cycles (SETTLE_CYCLES=4) then 00 -> cov[1] stays 0, no check on 01, busy=1, done=0.
- Saturation, CNT_W=2, DUT stuck c=0: alternate 01/00 five times, each held 6 cycles -> err_count=3 (saturated), cov=4'b0011, done=0.
- Reset mid-run: after 2 patterns checked, assert rst 1 cycle -> all outputs 0, state IDLE; pattern changes without start -> cov remains 0.
- Restart: in DONE with pass=0, pulse start -> next cycle done=0, err_count=0, cov=0, busy=1; a clean 4-pattern run then gives pass=1.
